residual_packer: RTL

- Stage directly downstream of the residual stage; consumes one `types::residual_compress_reg` per block (header, 32 residual pixels, compressable flag).
- Serializes the block into a stream of 32-bit words: two header words, then payload.
  - Payload is bit-packed residuals if compressable, raw residual bytes otherwise.
- Feeds the output/DMA word stream using valid/ready handshakes on both sides.

---
 rtl/residual_packer.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/residual_packer.sv
// Serializes one residual block into 32-bit words: two headers, then bit-packed or raw payload.
// Optional trailing XOR checksum word enabled by defining PACKER_CHECKSUM_EN.
package types;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } pixel_t;

  typedef struct packed {
    logic        skip_r;
    logic        skip_g;
    logic        skip_b;
    logic        skip_a;
    logic [11:0] bits_required;
    logic [7:0]  r_min;
    logic [7:0]  g_min;
    logic [7:0]  b_min;
    logic [7:0]  a_min;
  } block_header_t;

  typedef struct packed {
    block_header_t     header;
    pixel_t [31:0]     residual;
    logic              compressable;
  } residual_compress_reg;
endpackage

// One colour channel: effective width and the residual masked to that width.
module residual_packer_lane (
  input  logic [7:0] res,
  input  logic       skip,
  input  logic [2:0] br,
  output logic [3:0] width,
  output logic [7:0] bits
);
  logic [8:0] mask;

  always_comb begin
    width = skip ? 4'd0 : ({1'b0, br} + 4'd1);
    mask  = (9'd1 << width) - 9'd1;
    bits  = res & mask[7:0];
  end
endmodule

module residual_packer #(
  parameter int NUM_PIXELS = 32,
  parameter int OUT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  types::residual_compress_reg cr_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic                        out_last
);
  localparam int NCH = 4;

`ifdef PACKER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAYLOAD, CSUM} state_t;
  logic [OUT_W-1:0] csum_q, csum_d;
`else
  localparam bit CSUM_EN = 1'b0;
  typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAYLOAD} state_t;
`endif

  state_t                      state_q, state_d;
  types::residual_compress_reg blk_q, blk_d;
  logic [63:0]                 acc_q, acc_d;
  logic [6:0]                  acc_cnt_q, acc_cnt_d;
  logic [5:0]                  pix_cnt_q, pix_cnt_d;
  logic [5:0]                  pay_cnt_q, pay_cnt_d;
  logic                        out_valid_q, out_valid_d;
  logic [OUT_W-1:0]            out_data_q, out_data_d;
  logic                        out_last_q, out_last_d;

  logic xfer, out_free, accept, move, finish, append;
  logic empty_pay, pay_avail;
  logic [5:0] s_sum, pay_total;
  logic [5:0] off1, off2, off3;
  logic [63:0] pix_bits, acc_base;
  logic [6:0] cnt_base;

  types::pixel_t              cur_pix;
  logic [NCH-1:0][7:0]        ch_res;
  logic [NCH-1:0]             ch_skip;
  logic [NCH-1:0][2:0]        ch_br;
  logic [NCH-1:0][3:0]        ch_w;
  logic [NCH-1:0][7:0]        ch_bits;

  // Lane 0 is r, lane 3 is a; r lands in the lowest accumulator bits.
  assign cur_pix = blk_q.residual[pix_cnt_q[4:0]];
  assign ch_res  = {cur_pix.a, cur_pix.b, cur_pix.g, cur_pix.r};
  assign ch_skip = {blk_q.header.skip_a, blk_q.header.skip_b,
                    blk_q.header.skip_g, blk_q.header.skip_r};
  assign ch_br   = {blk_q.header.bits_required[2:0], blk_q.header.bits_required[5:3],
                    blk_q.header.bits_required[8:6], blk_q.header.bits_required[11:9]};

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    residual_packer_lane u_lane (
      .res   (ch_res[c]),
      .skip  (ch_skip[c]),
      .br    (ch_br[c]),
      .width (ch_w[c]),
      .bits  (ch_bits[c])
    );
  end

  always_comb begin
    off1     = {2'b0, ch_w[0]};
    off2     = off1 + {2'b0, ch_w[1]};
    off3     = off2 + {2'b0, ch_w[2]};
    s_sum    = off3 + {2'b0, ch_w[3]};
    pix_bits = {56'b0, ch_bits[0]}
             | ({56'b0, ch_bits[1]} << off1)
             | ({56'b0, ch_bits[2]} << off2)
             | ({56'b0, ch_bits[3]} << off3);
  end

  assign xfer      = out_valid_q && out_ready;
  assign out_free  = !out_valid_q || out_ready;
  assign accept    = (state_q == IDLE) && in_valid;
  assign empty_pay = blk_q.compressable && (s_sum == 6'd0);
  assign pay_total = blk_q.compressable ? s_sum : 6'(NUM_PIXELS);
  assign pay_avail = (pay_cnt_q < pay_total) &&
                     (!blk_q.compressable || (acc_cnt_q >= 7'd32));
  // The accumulator keeps filling while headers are on the wire.
  assign append    = blk_q.compressable && (s_sum != 6'd0) &&
                     (pix_cnt_q < 6'(NUM_PIXELS)) &&
                     (({1'b0, acc_cnt_q} + {2'b0, s_sum}) <= 8'd64) &&
                     (state_q == HDR0 || state_q == HDR1 || state_q == PAYLOAD);

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    pay_cnt_d   = pay_cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    move        = 1'b0;
    finish      = 1'b0;
`ifdef PACKER_CHECKSUM_EN
    csum_d      = xfer ? (csum_q ^ out_data_q) : csum_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        blk_d       = cr_in;
        pay_cnt_d   = '0;
        out_data_d  = {cr_in.compressable, cr_in.header.skip_r, cr_in.header.skip_g,
                       cr_in.header.skip_b, cr_in.header.skip_a,
                       cr_in.header.bits_required, 15'b0};
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        state_d     = HDR0;
`ifdef PACKER_CHECKSUM_EN
        csum_d      = '0;
`endif
      end
      HDR0: if (xfer) begin
        out_data_d  = {blk_q.header.r_min, blk_q.header.g_min,
                       blk_q.header.b_min, blk_q.header.a_min};
        out_valid_d = 1'b1;
        out_last_d  = empty_pay && !CSUM_EN;
        state_d     = HDR1;
      end
      HDR1: if (xfer) begin
        if (empty_pay) finish = 1'b1;
        else begin
          state_d = PAYLOAD;
          move    = pay_avail;
        end
      end
      PAYLOAD: begin
        if (xfer && (pay_cnt_q == pay_total)) finish = 1'b1;
        else if (out_free)                    move   = pay_avail;
      end
`ifdef PACKER_CHECKSUM_EN
      CSUM: if (xfer) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    if (move) begin
      out_data_d  = blk_q.compressable ? acc_q[31:0] : blk_q.residual[pay_cnt_q[4:0]];
      out_valid_d = 1'b1;
      out_last_d  = ((pay_cnt_q + 6'd1) == pay_total) && !CSUM_EN;
      pay_cnt_d   = pay_cnt_q + 6'd1;
    end

    if (finish) begin
`ifdef PACKER_CHECKSUM_EN
      out_data_d  = csum_q ^ out_data_q;
      out_valid_d = 1'b1;
      out_last_d  = 1'b1;
      state_d     = CSUM;
`else
      out_last_d  = 1'b0;
      state_d     = IDLE;
`endif
    end
  end

  // A move and an append may share a cycle; the append lands above the post-move count.
  always_comb begin
    acc_base = acc_q;
    cnt_base = acc_cnt_q;
    if (move && blk_q.compressable) begin
      acc_base = acc_q >> 32;
      cnt_base = acc_cnt_q - 7'd32;
    end
    acc_d     = acc_base;
    acc_cnt_d = cnt_base;
    pix_cnt_d = pix_cnt_q;
    if (accept) begin
      acc_d     = '0;
      acc_cnt_d = '0;
      pix_cnt_d = '0;
    end else if (append) begin
      acc_d     = acc_base | (pix_bits << cnt_base);
      acc_cnt_d = cnt_base + {1'b0, s_sum};
      pix_cnt_d = pix_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      pay_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
`ifdef PACKER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
endmodule
